// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the memory-access/writeback stage.
// Optional feature macro: MEM_WB_COMMIT_CNT_EN (enables the commit counter
// output on mem_wb_unit).
package mem_wb_pkg;

  localparam int XLEN_DEF = 64;
  localparam int RA_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [1:0] LD_B = 2'b00;
  localparam logic [1:0] LD_H = 2'b01;
  localparam logic [1:0] LD_W = 2'b10;
  localparam logic [1:0] LD_D = 2'b11;

  // A load is misaligned when its address is not a multiple of its size.
  function automatic logic ld_misaligned(input logic [1:0] size, input logic [2:0] lo);
    logic mis;
    case (size)
      LD_H:    mis = lo[0];
      LD_W:    mis = |lo[1:0];
      LD_D:    mis = |lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_wb_unit_load_fmt.sv
// Load data formatter: picks the addressed byte/half/word out of an aligned
// doubleword and sign- or zero-extends it. Purely combinational.
module load_fmt
  import mem_wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [2:0]      off_i,
  input  logic [1:0]      size_i,
  input  logic            uns_i,
  output logic [XLEN-1:0] res_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] word_sel;

  // Lane select by offset, then extend; unsigned flag has no effect on D.
  always_comb begin
    byte_sel = data_i[8*off_i +: 8];
    half_sel = data_i[16*off_i[2:1] +: 16];
    word_sel = data_i[32*off_i[2] +: 32];
    res_o    = data_i;
    case (size_i)
      LD_B:    res_o = uns_i ? {{(XLEN-8){1'b0}}, byte_sel}
                             : {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LD_H:    res_o = uns_i ? {{(XLEN-16){1'b0}}, half_sel}
                             : {{(XLEN-16){half_sel[15]}}, half_sel};
      LD_W:    res_o = uns_i ? {{(XLEN-32){1'b0}}, word_sel}
                             : {{(XLEN-32){word_sel[31]}}, word_sel};
      default: res_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_unit.sv
// Memory-access/writeback stage: sole writer of the integer register file.
// ALU results go straight to writeback; loads issue one doubleword read,
// format the response and write it back. One instruction in flight.
// Optional feature macro: MEM_WB_COMMIT_CNT_EN adds output commit_cnt,
// counting every cycle spent in writeback.
module mem_wb_unit
  import mem_wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_rd_wen,
  input  logic [XLEN-1:0] in_res,
  input  logic            in_is_load,
  input  logic [1:0]      in_ld_size,
  input  logic            in_ld_uns,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            wen,
  output logic [RA_W-1:0] waddr,
  output logic [XLEN-1:0] wdata,
  output logic            misalign,
  output logic            busy
`ifdef MEM_WB_COMMIT_CNT_EN
  ,
  output logic [XLEN-1:0] commit_cnt
`endif
);

  state_t            state_q, state_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic              rd_wen_q, rd_wen_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              is_load_q, is_load_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              misalign_q, misalign_d;
  logic [XLEN-1:0]   fmt_data;

  load_fmt #(.XLEN(XLEN)) u_load_fmt (
    .data_i (mem_rsp_data),
    .off_i  (addr_q[2:0]),
    .size_i (size_q),
    .uns_i  (uns_q),
    .res_o  (fmt_data)
  );

  // Next-state: accept in IDLE, handshake through REQ/WAIT, retire in WB.
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    rd_wen_d   = rd_wen_q;
    addr_d     = addr_q;
    data_d     = data_q;
    is_load_d  = is_load_q;
    size_d     = size_q;
    uns_d      = uns_q;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rd_d      = in_rd;
          rd_wen_d  = in_rd_wen;
          addr_d    = in_res;
          data_d    = in_res;
          is_load_d = in_is_load;
          size_d    = in_ld_size;
          uns_d     = in_ld_uns;
          if (!in_is_load) begin
            state_d = WB;
          end else if (ld_misaligned(in_ld_size, in_res[2:0])) begin
            misalign_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          data_d  = fmt_data;
          state_d = WB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-instruction registers; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      rd_wen_q   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      is_load_q  <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      rd_wen_q   <= rd_wen_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      is_load_q  <= is_load_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      misalign_q <= misalign_d;
    end
  end

  // Outputs decoded from state; write port is quiet outside WB.
  always_comb begin
    in_ready      = (state_q == IDLE);
    busy          = (state_q != IDLE);
    mem_req_valid = (state_q == REQ);
    mem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
    misalign      = misalign_q;
    wen           = 1'b0;
    waddr         = '0;
    wdata         = '0;
    if (state_q == WB) begin
      wen   = rd_wen_q && (rd_q != '0);
      waddr = rd_q;
      wdata = data_q;
    end
  end

`ifdef MEM_WB_COMMIT_CNT_EN
  logic [XLEN-1:0] commit_cnt_q, commit_cnt_d;

  // Retired-instruction count, including x0 destinations; wraps naturally.
  always_comb begin
    commit_cnt_d = commit_cnt_q;
    if (state_q == WB) commit_cnt_d = commit_cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) commit_cnt_q <= '0;
    else     commit_cnt_q <= commit_cnt_d;
  end

  assign commit_cnt = commit_cnt_q;
`endif

  // is_load is kept with the instruction for completeness of the latch set.
  logic unused_ok;
  assign unused_ok = is_load_q;

endmodule

// File: tb/tb_mem_wb_unit.sv
// Testbench for mem_wb_unit: directed vector table, hand-written reset and
// counter sequences, and randomized operations against a byte-level model.
module tb_mem_wb_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic        in_rd_wen = 1'b0;
  logic [63:0] in_res = '0;
  logic        in_is_load = 1'b0;
  logic [1:0]  in_ld_size = '0;
  logic        in_ld_uns = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_data = '0;
  logic        wen;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic        misalign;
  logic        busy;
`ifdef MEM_WB_COMMIT_CNT_EN
  logic [63:0] commit_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mem_wb_unit dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_rd_wen     (in_rd_wen),
    .in_res        (in_res),
    .in_is_load    (in_is_load),
    .in_ld_size    (in_ld_size),
    .in_ld_uns     (in_ld_uns),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .wen           (wen),
    .waddr         (waddr),
    .wdata         (wdata),
    .misalign      (misalign),
    .busy          (busy)
`ifdef MEM_WB_COMMIT_CNT_EN
    ,
    .commit_cnt    (commit_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: gather the addressed bytes little-endian, then extend.
  function automatic logic [63:0] model_ld(input logic [63:0] data, input logic [63:0] addr,
                                           input logic [1:0] sz, input logic uns);
    int n = 1 << sz;
    int off = int'(addr[2:0]);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++)
      v |= ((data >> (8 * (off + i))) & 64'hFF) << (8 * i);
    if (!uns && n < 8)
      v = 64'($signed(v << (64 - 8 * n)) >>> (64 - 8 * n));
    return v;
  endfunction

  function automatic logic model_mis(input logic [63:0] addr, input logic [1:0] sz);
    return (int'(addr[2:0]) % (1 << sz)) != 0;
  endfunction

  // Runs one instruction from an IDLE negedge back to an IDLE negedge.
  task automatic do_op(input string tag, input logic ld, input logic [1:0] sz, input logic uns,
                       input logic [63:0] res, input logic [4:0] rd, input logic rdw,
                       input logic [63:0] rsp, input int req_lat, input int rsp_lat,
                       input logic e_mis, input logic e_wen, input logic [63:0] e_wdata);
    chk({tag, ".ready0"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_is_load = ld; in_ld_size = sz; in_ld_uns = uns;
    in_res = res; in_rd = rd; in_rd_wen = rdw;
    @(negedge clk);
    in_valid = 1'b0;
    in_res = {$urandom, $urandom};
    if (e_mis) begin
      chk({tag, ".mis"}, 64'(misalign), 64'd1);
      chk({tag, ".mis_req"}, 64'(mem_req_valid), 64'd0);
      chk({tag, ".mis_wen"}, 64'(wen), 64'd0);
      chk({tag, ".mis_busy"}, 64'(busy), 64'd0);
      @(negedge clk);
      chk({tag, ".mis_pulse"}, 64'(misalign), 64'd0);
      chk({tag, ".mis_wen2"}, 64'(wen), 64'd0);
    end else begin
      if (ld) begin
        for (int k = 0; k <= req_lat; k++) begin
          chk({tag, ".req_v"}, 64'(mem_req_valid), 64'd1);
          chk({tag, ".req_a"}, mem_req_addr, res & ~64'h7);
          chk({tag, ".req_rdy"}, 64'(in_ready), 64'd0);
          mem_req_ready = (k == req_lat);
          mem_rsp_valid = 1'b1;
          mem_rsp_data = {$urandom, $urandom};
          @(negedge clk);
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        for (int j = 0; j <= rsp_lat; j++) begin
          chk({tag, ".wait_req"}, 64'(mem_req_valid), 64'd0);
          chk({tag, ".wait_wen"}, 64'(wen), 64'd0);
          if (j == rsp_lat) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data = rsp;
          end
          @(negedge clk);
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_data = {$urandom, $urandom};
      end
      chk({tag, ".wen"}, 64'(wen), 64'(e_wen));
      chk({tag, ".waddr"}, 64'(waddr), 64'(rd));
      chk({tag, ".wdata"}, wdata, e_wdata);
      chk({tag, ".wb_rdy"}, 64'(in_ready), 64'd0);
      chk({tag, ".wb_busy"}, 64'(busy), 64'd1);
      @(negedge clk);
      chk({tag, ".post_wen"}, 64'(wen), 64'd0);
      chk({tag, ".post_wdata"}, wdata, 64'd0);
      chk({tag, ".post_busy"}, 64'(busy), 64'd0);
    end
  endtask

  typedef struct {
    string       nm;
    logic        ld;
    logic [1:0]  sz;
    logic        uns;
    logic [63:0] res;
    logic [4:0]  rd;
    logic        rdw;
    logic [63:0] rsp;
    int          req_lat;
    int          rsp_lat;
    logic        e_mis;
    logic        e_wen;
    logic [63:0] e_wdata;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{"alu",     1'b0, 2'd0, 1'b0, 64'h1234, 5'd5,  1'b1, 64'h0, 0, 0, 1'b0, 1'b1, 64'h1234};
    tbl[1]  = '{"lb_s",    1'b1, 2'd0, 1'b0, 64'h1003, 5'd7,  1'b1, 64'h0000_0000_8000_0000, 0, 0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
    tbl[2]  = '{"lbu",     1'b1, 2'd0, 1'b1, 64'h1003, 5'd7,  1'b1, 64'h0000_0000_8000_0000, 0, 1, 1'b0, 1'b1, 64'h80};
    tbl[3]  = '{"lw_stall",1'b1, 2'd2, 1'b0, 64'h2004, 5'd9,  1'b1, 64'hDEAD_BEEF_0000_0001, 3, 0, 1'b0, 1'b1, 64'hFFFF_FFFF_DEAD_BEEF};
    tbl[4]  = '{"lh_mis",  1'b1, 2'd1, 1'b0, 64'h11,   5'd3,  1'b1, 64'h0, 0, 0, 1'b1, 1'b0, 64'h0};
    tbl[5]  = '{"alu_x0",  1'b0, 2'd0, 1'b0, 64'h55,   5'd0,  1'b1, 64'h0, 0, 0, 1'b0, 1'b0, 64'h55};
    tbl[6]  = '{"ld_uns",  1'b1, 2'd3, 1'b1, 64'h3000, 5'd31, 1'b1, 64'h8000_0000_0000_0001, 1, 2, 1'b0, 1'b1, 64'h8000_0000_0000_0001};
    tbl[7]  = '{"lwu",     1'b1, 2'd2, 1'b1, 64'h2004, 5'd12, 1'b1, 64'hDEAD_BEEF_0000_0001, 0, 0, 1'b0, 1'b1, 64'h0000_0000_DEAD_BEEF};
    tbl[8]  = '{"lh_s",    1'b1, 2'd1, 1'b0, 64'h16,   5'd4,  1'b1, 64'h8001_0000_0000_0000, 0, 0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_8001};
    tbl[9]  = '{"lb_nowen",1'b1, 2'd0, 1'b0, 64'h7,    5'd6,  1'b0, 64'h7F00_0000_0000_0000, 0, 0, 1'b0, 1'b0, 64'h7F};
    tbl[10] = '{"ld_mis",  1'b1, 2'd3, 1'b0, 64'h4004, 5'd8,  1'b1, 64'h0, 0, 0, 1'b1, 1'b0, 64'h0};
    tbl[11] = '{"lw_mis",  1'b1, 2'd2, 1'b0, 64'h2,    5'd8,  1'b1, 64'h0, 0, 0, 1'b1, 1'b0, 64'h0};

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.wen", 64'(wen), 64'd0);
    chk("rst.waddr", 64'(waddr), 64'd0);
    chk("rst.wdata", wdata, 64'd0);
    chk("rst.req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst.misalign", 64'(misalign), 64'd0);
`ifdef MEM_WB_COMMIT_CNT_EN
    chk("rst.commit_cnt", commit_cnt, 64'd0);
`endif

    // Directed vector table.
    for (int i = 0; i < 12; i++)
      do_op(tbl[i].nm, tbl[i].ld, tbl[i].sz, tbl[i].uns, tbl[i].res, tbl[i].rd, tbl[i].rdw,
            tbl[i].rsp, tbl[i].req_lat, tbl[i].rsp_lat, tbl[i].e_mis, tbl[i].e_wen, tbl[i].e_wdata);

    // Reset while waiting for the response; the late response must be ignored.
    in_valid = 1'b1; in_is_load = 1'b1; in_ld_size = 2'd0; in_ld_uns = 1'b0;
    in_res = 64'h40; in_rd = 5'd10; in_rd_wen = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstw.req", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rstw.in_wait", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw.busy", 64'(busy), 64'd0);
    chk("rstw.in_ready", 64'(in_ready), 64'd1);
    chk("rstw.wen", 64'(wen), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 64'h1111_2222_3333_4444;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("rstw.late_wen", 64'(wen), 64'd0);
    chk("rstw.late_busy", 64'(busy), 64'd0);
    chk("rstw.late_wdata", wdata, 64'd0);

`ifdef MEM_WB_COMMIT_CNT_EN
    // Counter restarts from reset; x0 writes count, misaligned drops do not.
    chk("cnt.zero", commit_cnt, 64'd0);
    do_op("cnt_a", 1'b0, 2'd0, 1'b0, 64'hA, 5'd3, 1'b1, 64'h0, 0, 0, 1'b0, 1'b1, 64'hA);
    do_op("cnt_b", 1'b0, 2'd0, 1'b0, 64'hB, 5'd0, 1'b1, 64'h0, 0, 0, 1'b0, 1'b0, 64'hB);
    do_op("cnt_m", 1'b1, 2'd2, 1'b0, 64'h21, 5'd3, 1'b1, 64'h0, 0, 0, 1'b1, 1'b0, 64'h0);
    do_op("cnt_c", 1'b1, 2'd3, 1'b0, 64'h8, 5'd2, 1'b1, 64'h5, 0, 0, 1'b0, 1'b1, 64'h5);
    chk("cnt.three", commit_cnt, 64'd3);
`endif

    // Randomized operations against the byte-level model.
    for (int n = 0; n < 60; n++) begin
      logic        ld, uns, rdw, mis;
      logic [1:0]  sz;
      logic [63:0] addr, rsp, exp_d;
      logic [4:0]  rd;
      ld   = ($urandom_range(0, 2) != 0);
      sz   = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~64'((1 << sz) - 1);
      rd   = 5'($urandom_range(0, 31));
      rdw  = 1'($urandom_range(0, 1));
      rsp  = {$urandom, $urandom};
      mis  = ld && model_mis(addr, sz);
      exp_d = ld ? model_ld(rsp, addr, sz, uns) : addr;
      do_op($sformatf("rnd%0d", n), ld, sz, uns, addr, rd, rdw, rsp,
            $urandom_range(0, 2), $urandom_range(0, 2), mis, rdw && (rd != 0), exp_d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
